// File: rtl/square_channel.sv
// square_channel: duty-cycle square-wave tone channel with length counter and volume envelope.
module square_channel #(
  parameter int PERIOD_W = 11,
  parameter int LEN_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          duty,
  input  logic [LEN_W-1:0]    length_load,
  input  logic                length_en,
  input  logic [3:0]          vol_init,
  input  logic                env_dir,
  input  logic [2:0]          env_pace,
  input  logic                frame_tick,
  input  logic                env_tick,
  output logic [7:0]          chl_out,
  output logic                active
);
  logic                r_active;
  logic [PERIOD_W-1:0] r_timer;
  logic [2:0]          r_step;
  logic [LEN_W:0]      r_len;
  logic [3:0]          r_vol;
  logic [2:0]          r_env_cnt;
  logic [7:0]          r_out;
  logic                w_high;
  logic [3:0]          w_vol_next;
  logic [LEN_W:0]      w_len_load;
  logic [LEN_W:0]      w_len_one;
  always_comb begin
    w_high = duty == 2'b00 ? r_step == 3'd7 :
             duty == 2'b01 ? r_step[2:1] == 2'b11 :
             duty == 2'b10 ? r_step[2] : r_step < 3'd6;
    w_vol_next = env_dir ? (r_vol == 4'd15 ? r_vol : r_vol + 4'd1)
                         : (r_vol == 4'd0 ? r_vol : r_vol - 4'd1);
    w_len_one  = {{LEN_W{1'b0}}, 1'b1};
    w_len_load = {1'b1, {LEN_W{1'b0}}} - {1'b0, length_load};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_timer   <= '0;
      r_step    <= '0;
      r_len     <= '0;
      r_vol     <= '0;
      r_env_cnt <= '0;
      r_out     <= 8'h00;
    end else begin
      r_out <= (r_active && w_high) ? {r_vol, r_vol} : 8'h00;
      if (trigger) begin
        r_timer   <= period;
        r_step    <= '0;
        r_len     <= w_len_load;
        r_vol     <= vol_init;
        r_env_cnt <= env_pace;
        r_active  <= (vol_init != 4'd0) || env_dir;
      end else if (r_active) begin
        if (r_timer == '0) begin
          r_timer <= period;
          r_step  <= r_step + 3'd1;
        end else begin
          r_timer <= r_timer - PERIOD_W'(1);
        end
        if (frame_tick && length_en) begin
          r_len <= r_len - w_len_one;
          if (r_len == w_len_one) r_active <= 1'b0;
        end
        // A counter left at 0 by a pace-0 trigger wraps through 7 until its next reload.
        if (env_tick && env_pace != 3'd0) begin
          if (r_env_cnt == 3'd1) begin
            r_env_cnt <= env_pace;
            r_vol     <= w_vol_next;
          end else begin
            r_env_cnt <= r_env_cnt - 3'd1;
          end
        end
      end
    end
  end
  assign chl_out = r_out;
  assign active  = r_active;
endmodule
